// File: rtl/ram_banked.sv
// Banked on-chip data RAM mapped just below RAMTOP: 2^BANKBITS low-order-interleaved
// banks, each with a registered read port, a write port and a post-reset zero-fill.
module ram_banked #(
    parameter int          AW             = 15,
    parameter int          ADDRBITS       = 10,
    parameter int          BANKBITS       = 1,
    parameter int unsigned RAMTOP         = 32'h0000_4000,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [(AW << BANKBITS)-1:0] read_addr,
    input  logic [(1 << BANKBITS)-1:0]  read_en,
    output logic [(8 << BANKBITS)-1:0]  read_data,
    output logic [(1 << BANKBITS)-1:0]  read_valid,
    output logic [(1 << BANKBITS)-1:0]  read_err,
    input  logic [(AW << BANKBITS)-1:0] write_addr,
    input  logic [(8 << BANKBITS)-1:0]  write_data,
    input  logic [(1 << BANKBITS)-1:0]  write_en,
    output logic [(1 << BANKBITS)-1:0]  write_err,
    output logic                        busy
);

    localparam int          NB        = 1 << BANKBITS;
    localparam int          WW        = ADDRBITS - BANKBITS;
    localparam int          DEPTH     = 1 << WW;
    localparam int unsigned WINDOW    = 32'd1 << ADDRBITS;
    localparam int unsigned BASE      = RAMTOP - WINDOW;
    localparam logic [AW-1:0] BASE_AW   = AW'(BASE);
    localparam logic [AW-1:0] BANK_MASK = AW'(NB - 1);
    localparam logic [WW-1:0] CNT_LAST  = WW'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_READY = 2'd2
    } state_t;

    function automatic logic in_window(input logic [AW-1:0] addr);
        logic [31:0] a;
        a = 32'(addr);
        return (a >= BASE) && (a < RAMTOP);
    endfunction

    function automatic logic [AW-1:0] offset_of(input logic [AW-1:0] addr);
        return addr - BASE_AW;
    endfunction

    function automatic logic bank_match(input logic [AW-1:0] addr, input int bank);
        return (offset_of(addr) & BANK_MASK) == AW'(bank);
    endfunction

    function automatic logic [WW-1:0] word_of(input logic [AW-1:0] addr);
        logic [AW-1:0] sh;
        sh = offset_of(addr) >> BANKBITS;
        return sh[WW-1:0];
    endfunction

    state_t        r_state;
    state_t        w_state_nxt;
    logic [WW-1:0] r_clr_cnt;
    logic [WW-1:0] w_clr_cnt_nxt;
    logic          r_busy;
    logic          w_clr_we;
    logic          w_port_en;

    // State register: reset parks the FSM in IDLE so busy stays low while reset is held
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_clr_cnt <= {WW{1'b0}};
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_cnt <= w_clr_cnt_nxt;
            r_busy    <= (w_state_nxt == ST_CLEAR);
        end
    end

    // Next-state logic: one word per bank is zeroed per CLEAR cycle
    always_comb begin
        w_state_nxt   = r_state;
        w_clr_cnt_nxt = r_clr_cnt;
        case (r_state)
            ST_IDLE: begin
                w_clr_cnt_nxt = {WW{1'b0}};
                if (CLEAR_ON_RESET) begin
                    w_state_nxt = ST_CLEAR;
                end else begin
                    w_state_nxt = ST_READY;
                end
            end
            ST_CLEAR: begin
                w_clr_cnt_nxt = r_clr_cnt + WW'(1);
                if (r_clr_cnt == CNT_LAST) begin
                    w_state_nxt = ST_READY;
                end else begin
                    w_state_nxt = ST_CLEAR;
                end
            end
            ST_READY: begin
                w_state_nxt = ST_READY;
            end
            default: begin
                w_state_nxt   = ST_IDLE;
                w_clr_cnt_nxt = {WW{1'b0}};
            end
        endcase
    end

    // Output decode: ports are live only in READY and never on a reset edge
    always_comb begin
        w_clr_we  = 1'b0;
        w_port_en = 1'b0;
        case (r_state)
            ST_CLEAR: begin
                w_clr_we  = ~reset;
                w_port_en = 1'b0;
            end
            ST_READY: begin
                w_clr_we  = 1'b0;
                w_port_en = ~reset;
            end
            default: begin
                w_clr_we  = 1'b0;
                w_port_en = 1'b0;
            end
        endcase
    end

    assign busy = r_busy;

    for (genvar gi = 0; gi < NB; gi++) begin : g_bank
        logic [7:0]    r_mem [DEPTH];
        logic [7:0]    r_rd_data;
        logic          r_rd_valid;
        logic          r_rd_err;
        logic          r_wr_err;
        logic [AW-1:0] w_ra;
        logic [AW-1:0] w_wa;
        logic [WW-1:0] w_rd_word;
        logic [WW-1:0] w_wr_word;
        logic [WW-1:0] w_mem_addr;
        logic [7:0]    w_wr_data;
        logic [7:0]    w_mem_wdata;
        logic          w_rd_req;
        logic          w_wr_req;
        logic          w_rd_ok;
        logic          w_wr_ok;
        logic          w_bypass;
        logic          w_mem_we;

        // Port decode and sharing of the array write port between clear and CPU writes
        always_comb begin
            w_ra      = read_addr[gi*AW +: AW];
            w_wa      = write_addr[gi*AW +: AW];
            w_wr_data = write_data[gi*8 +: 8];
            w_rd_req  = read_en[gi] & w_port_en;
            w_wr_req  = write_en[gi] & w_port_en;
            w_rd_ok   = in_window(w_ra) & bank_match(w_ra, gi);
            w_wr_ok   = in_window(w_wa) & bank_match(w_wa, gi);
            w_rd_word = word_of(w_ra);
            w_wr_word = word_of(w_wa);
            w_bypass  = w_rd_ok & w_wr_req & w_wr_ok & (w_rd_word == w_wr_word);
            if (w_clr_we) begin
                w_mem_we    = 1'b1;
                w_mem_addr  = r_clr_cnt;
                w_mem_wdata = 8'h00;
            end else begin
                w_mem_we    = w_wr_req & w_wr_ok;
                w_mem_addr  = w_wr_word;
                w_mem_wdata = w_wr_data;
            end
        end

        // Bank storage write port
        always_ff @(posedge clk) begin
            if (w_mem_we) begin
                r_mem[w_mem_addr] <= w_mem_wdata;
            end
        end

        // Registered read port; a same-word legal write is forwarded (write-first)
        always_ff @(posedge clk) begin
            if (reset) begin
                r_rd_data  <= 8'h00;
                r_rd_valid <= 1'b0;
                r_rd_err   <= 1'b0;
                r_wr_err   <= 1'b0;
            end else begin
                r_rd_valid <= w_rd_req;
                r_wr_err   <= w_wr_req & ~w_wr_ok;
                if (w_rd_req) begin
                    if (!w_rd_ok) begin
                        r_rd_data <= 8'hFF;
                        r_rd_err  <= 1'b1;
                    end else if (w_bypass) begin
                        r_rd_data <= w_wr_data;
                        r_rd_err  <= 1'b0;
                    end else begin
                        r_rd_data <= r_mem[w_rd_word];
                        r_rd_err  <= 1'b0;
                    end
                end else if (!w_port_en) begin
                    r_rd_err <= 1'b0;
                end else begin
                    r_rd_err <= r_rd_err;
                end
            end
        end

        assign read_data[gi*8 +: 8] = r_rd_data;
        assign read_valid[gi]       = r_rd_valid;
        assign read_err[gi]         = r_rd_err;
        assign write_err[gi]        = r_wr_err;
    end

endmodule

// File: tb/tb_ram_banked.sv
// Scoreboard bench for ram_banked: a byte-addressed reference model predicts every
// response; a negedge monitor compares them. Two instances cover both configurations.
module tb_ram_banked;
    localparam int AW = 15;
    localparam int PH_IDLE = 0, PH_CLEAR = 1, PH_READY = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0, rst1;
    logic [2*AW-1:0] d0_ra, d0_wa;
    logic [15:0]     d0_wd, d0_rd;
    logic [1:0]      d0_re, d0_we, d0_rv, d0_rerr, d0_werr;
    logic            d0_busy;
    logic [4*AW-1:0] d1_ra, d1_wa;
    logic [31:0]     d1_wd, d1_rd;
    logic [3:0]      d1_re, d1_we, d1_rv, d1_rerr, d1_werr;
    logic            d1_busy;

    logic [AW-1:0] ra [2][4];
    logic [AW-1:0] wa [2][4];
    logic [7:0]    wd [2][4];
    logic          re [2][4];
    logic          we [2][4];

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            d0_ra[i*AW +: AW] = ra[0][i];
            d0_wa[i*AW +: AW] = wa[0][i];
            d0_wd[i*8 +: 8]   = wd[0][i];
            d0_re[i]          = re[0][i];
            d0_we[i]          = we[0][i];
        end
        for (int i = 0; i < 4; i++) begin
            d1_ra[i*AW +: AW] = ra[1][i];
            d1_wa[i*AW +: AW] = wa[1][i];
            d1_wd[i*8 +: 8]   = wd[1][i];
            d1_re[i]          = re[1][i];
            d1_we[i]          = we[1][i];
        end
    end

    ram_banked u_dut0 (
        .clk(clk), .reset(rst0),
        .read_addr(d0_ra), .read_en(d0_re), .read_data(d0_rd),
        .read_valid(d0_rv), .read_err(d0_rerr),
        .write_addr(d0_wa), .write_data(d0_wd), .write_en(d0_we),
        .write_err(d0_werr), .busy(d0_busy)
    );

    ram_banked #(
        .AW(15), .ADDRBITS(12), .BANKBITS(2),
        .RAMTOP(32'h0000_4000), .CLEAR_ON_RESET(1'b0)
    ) u_dut1 (
        .clk(clk), .reset(rst1),
        .read_addr(d1_ra), .read_en(d1_re), .read_data(d1_rd),
        .read_valid(d1_rv), .read_err(d1_rerr),
        .write_addr(d1_wa), .write_data(d1_wd), .write_en(d1_we),
        .write_err(d1_werr), .busy(d1_busy)
    );

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [1:0] busy;
        logic [1:0] rst;
        logic [7:0] rv;
        logic [7:0] we;
    } cyc_t;
    typedef struct packed {
        logic [7:0] d;
        logic       err;
    } rexp_t;

    cyc_t  q_cyc [$];
    rexp_t rq [8][$];
    logic [7:0] m_mem   [2][4096];
    bit         m_known [2][4096];
    int m_phase [2] = '{PH_IDLE, PH_IDLE};
    int m_left  [2] = '{0, 0};
    int n_chk = 0;
    int n_fail = 0;

    function automatic int nbk(input int k);
        return (k == 0) ? 2 : 4;
    endfunction
    function automatic int basek(input int k);
        return (k == 0) ? 32'h3C00 : 32'h3000;
    endfunction
    function automatic bit legal(input int k, input int i, input int a);
        return (a >= basek(k)) && (a < 32'h4000) && (((a - basek(k)) % nbk(k)) == i);
    endfunction

    task automatic clr_in();
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 4; i++) begin
                ra[k][i] = '0; wa[k][i] = '0; wd[k][i] = 8'h00;
                re[k][i] = 1'b0; we[k][i] = 1'b0;
            end
    endtask
    task automatic rd(input int k, input int i, input int a);
        ra[k][i] = AW'(a); re[k][i] = 1'b1;
    endtask
    task automatic wr(input int k, input int i, input int a, input int d);
        wa[k][i] = AW'(a); wd[k][i] = 8'(d); we[k][i] = 1'b1;
    endtask

    // Apply the model to the inputs presented now, then advance one clock
    task automatic tick();
        cyc_t  e;
        rexp_t r;
        int    a;
        e = '0;
        for (int k = 0; k < 2; k++) begin
            e.rst[k] = (k == 0) ? rst0 : rst1;
            if (e.rst[k]) begin
                m_phase[k] = PH_IDLE;
            end else if (m_phase[k] == PH_IDLE) begin
                if (k == 0) begin
                    m_phase[k] = PH_CLEAR;
                    m_left[k]  = 512;
                    for (int b = 0; b < 1024; b++) begin
                        m_mem[k][b] = 8'h00; m_known[k][b] = 1'b1;
                    end
                end else begin
                    m_phase[k] = PH_READY;
                end
            end else if (m_phase[k] == PH_CLEAR) begin
                m_left[k]--;
                if (m_left[k] == 0) m_phase[k] = PH_READY;
            end else begin
                for (int i = 0; i < nbk(k); i++) begin
                    if (we[k][i]) begin
                        a = int'(wa[k][i]);
                        if (legal(k, i, a)) begin
                            m_mem[k][a - basek(k)]   = wd[k][i];
                            m_known[k][a - basek(k)] = 1'b1;
                        end else begin
                            e.we[k*4+i] = 1'b1;
                        end
                    end
                end
                for (int i = 0; i < nbk(k); i++) begin
                    if (re[k][i]) begin
                        a = int'(ra[k][i]);
                        e.rv[k*4+i] = 1'b1;
                        if (legal(k, i, a)) begin
                            r.d = m_mem[k][a - basek(k)]; r.err = 1'b0;
                        end else begin
                            r.d = 8'hFF; r.err = 1'b1;
                        end
                        rq[k*4+i].push_back(r);
                    end
                end
            end
            e.busy[k] = (m_phase[k] == PH_CLEAR);
        end
        @(posedge clk);
        q_cyc.push_back(e);
        #1;
    endtask

    function automatic int pick(input int k, input int i);
        if ($urandom_range(0, 4) == 0)
            return int'($urandom_range(basek(k) - 8, 32'h4007));
        return basek(k) + int'($urandom_range(0, 15)) * nbk(k) + i;
    endfunction

    task automatic rand_in();
        int a;
        clr_in();
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < nbk(k); i++) begin
                if ($urandom_range(0, 1) == 1) wr(k, i, pick(k, i), int'($urandom_range(0, 255)));
                if ($urandom_range(0, 1) == 1) begin
                    a = pick(k, i);
                    if (!legal(k, i, a) || m_known[k][a - basek(k)]) rd(k, i, a);
                end
            end
    endtask

    // ---------------- monitor ----------------
    function automatic logic [7:0] rd_of(input int k, input int i);
        logic [31:0] t;
        t = (k == 0) ? {16'h0000, d0_rd} : d1_rd;
        return t[i*8 +: 8];
    endfunction
    function automatic logic out_bit(input int k, input int sel, input int i);
        logic [3:0] v;
        case (sel)
            0:       v = (k == 0) ? {2'b00, d0_rv}   : d1_rv;
            1:       v = (k == 0) ? {2'b00, d0_rerr} : d1_rerr;
            default: v = (k == 0) ? {2'b00, d0_werr} : d1_werr;
        endcase
        return v[i];
    endfunction

    task automatic chk(input string nm, input int k, input int i,
                       input logic [8:0] act, input logic [8:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d port%0d t=%0t: got %0h, expected %0h", nm, k, i, $time, act, exp);
        end
    endtask

    cyc_t  mon_e;
    rexp_t mon_r;
    always @(negedge clk) begin
        if (q_cyc.size() > 0) begin
            mon_e = q_cyc.pop_front();
            for (int k = 0; k < 2; k++) begin
                chk("busy", k, 0, 9'((k == 0) ? d0_busy : d1_busy), 9'(mon_e.busy[k]));
                for (int i = 0; i < nbk(k); i++) begin
                    chk("write_err", k, i, 9'(out_bit(k, 2, i)), 9'(mon_e.we[k*4+i]));
                    chk("read_valid", k, i, 9'(out_bit(k, 0, i)), 9'(mon_e.rv[k*4+i]));
                    if (mon_e.rst[k]) begin
                        chk("reset_data", k, i, {1'b0, rd_of(k, i)}, 9'h000);
                        chk("reset_rerr", k, i, 9'(out_bit(k, 1, i)), 9'h000);
                    end
                    if (out_bit(k, 0, i) === 1'b1) begin
                        if (rq[k*4+i].size() == 0) begin
                            n_chk++; n_fail++;
                            $display("FAIL unexpected_read dut%0d port%0d: got valid, expected none", k, i);
                        end else begin
                            mon_r = rq[k*4+i].pop_front();
                            chk("read_data", k, i, {1'b0, rd_of(k, i)}, {1'b0, mon_r.d});
                            chk("read_err", k, i, 9'(out_bit(k, 1, i)), 9'(mon_r.err));
                        end
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        clr_in();
        rst0 = 1'b1; rst1 = 1'b1;
        tick(); tick();
        rst0 = 1'b0; rst1 = 1'b0;
        repeat (520) tick();

        rd(0, 0, 32'h3C00); rd(0, 1, 32'h3FFF); tick(); clr_in();
        wr(0, 0, 32'h3C10, 8'hA5); wr(0, 1, 32'h3C11, 8'h5A); tick(); clr_in();
        rd(0, 0, 32'h3C10); rd(0, 1, 32'h3C11); tick(); clr_in();
        wr(0, 0, 32'h3D20, 8'h3C); rd(0, 0, 32'h3D20); tick(); clr_in();
        wr(0, 0, 32'h3C11, 8'hEE); tick(); clr_in();
        wr(0, 0, 32'h3BFF, 8'hEE); rd(0, 0, 32'h4000); tick(); clr_in();
        rd(0, 1, 32'h3C11); tick(); clr_in();

        // Contents survive reset when the clear sequence is disabled
        wr(1, 3, 32'h3003, 8'h77); tick(); clr_in();
        rst1 = 1'b1; tick(); rst1 = 1'b0; tick(); tick();
        rd(1, 3, 32'h3003); tick(); clr_in();

        repeat (400) begin
            rand_in(); tick();
        end
        clr_in(); tick();

        // Reset during clear restarts it; writes while busy are dropped
        rst0 = 1'b1; tick(); rst0 = 1'b0;
        repeat (200) tick();
        rst0 = 1'b1; tick(); rst0 = 1'b0;
        wr(0, 0, 32'h3C20, 8'h99); wr(0, 1, 32'h3C21, 8'h66); tick(); clr_in();
        repeat (100) tick();
        wr(0, 0, 32'h3C20, 8'h98); rd(0, 1, 32'h3C21); tick(); clr_in();
        repeat (450) tick();
        rd(0, 0, 32'h3C20); rd(0, 1, 32'h3C21); tick(); clr_in();
        repeat (3) tick();
        @(negedge clk); #1;

        for (int q = 0; q < 8; q++) chk("pending_reads", q / 4, q % 4, 9'(rq[q].size()), 9'h000);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
